buzz_sched: RTL and testbench

//  Scheduler that shares the single piezo buzzer between three requesters:

---
 rtl/buzz_sched.sv | 214 +++++++++++++++++++++
 tb/tb_buzz_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzz_sched.sv
`default_nettype none
// ============================================================================
// Module   : buzz_sched
// Purpose  : Shares one piezo buzzer between alarm melody, hourly chime and
//            key-click; fixed priority, beep/melody sequencing, nco divisor.
// Revision : 1.0  initial release
// ============================================================================
module buzz_sched #(
    parameter int TICK_DIV    = 500000,
    parameter int KEY_TICKS   = 5,
    parameter int CHIME_ON    = 20,
    parameter int CHIME_OFF   = 10,
    parameter int CHIME_BEEPS = 3,
    parameter int ALARM_STEP  = 50,
    parameter int TONE_KEY    = 6327,
    parameter int TONE_CHIME  = 7102
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_alarm_req,
    input  logic        i_chime_req,
    input  logic        i_key_req,
    input  logic        i_stop,
    output logic [31:0] o_nco_num,
    output logic        o_buzz_en,
    output logic [2:0]  o_grant,
    output logic        o_busy
);

    localparam int                 c_PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_KEY       = 3'd1,
        S_CHIME_ON  = 3'd2,
        S_CHIME_OFF = 3'd3,
        S_ALARM     = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_PRE_W-1:0] r_prescale, w_prescale_nxt;
    logic [15:0]        r_ticks, w_ticks_nxt;
    logic [7:0]         r_beep, w_beep_nxt;
    logic [2:0]         r_step, w_step_nxt;
    logic               r_pend_chime, w_pend_chime_nxt;
    logic               r_pend_key, w_pend_key_nxt;
    logic               r_mask, w_mask_nxt;
    logic [31:0]        r_nco, w_nco_nxt;
    logic               r_buzz, w_buzz_nxt;
    logic [2:0]         r_grant, w_grant_nxt;
    logic               r_busy;
    logic               w_tick, w_alarm_ok, w_enter;

    // Melody E,D,C,D,E,E,E,D as nco divisors
    function automatic logic [31:0] melody(input logic [2:0] idx);
        case (idx)
            3'd1, 3'd3, 3'd7: melody = 32'd10641;
            3'd2:             melody = 32'd11944;
            default:          melody = 32'd9480;
        endcase
    endfunction

    always_comb begin
        w_tick           = (r_prescale == c_PRE_MAX);
        w_alarm_ok       = i_alarm_req & ~r_mask;
        w_mask_nxt       = i_alarm_req & (r_mask | i_stop);
        w_state_nxt      = r_state;
        w_enter          = 1'b0;
        w_prescale_nxt   = w_tick ? '0 : r_prescale + c_PRE_W'(1);
        w_ticks_nxt      = w_tick ? r_ticks + 16'd1 : r_ticks;
        w_beep_nxt       = r_beep;
        w_step_nxt       = r_step;
        w_nco_nxt        = r_nco;
        w_buzz_nxt       = r_buzz;
        w_grant_nxt      = r_grant;
        w_pend_chime_nxt = r_pend_chime | i_chime_req;
        w_pend_key_nxt   = r_pend_key | i_key_req;

        if (i_stop) begin
            w_state_nxt      = S_IDLE;
            w_enter          = 1'b1;
            w_pend_chime_nxt = 1'b0;
            w_pend_key_nxt   = 1'b0;
            w_buzz_nxt       = 1'b0;
            w_grant_nxt      = 3'b000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_alarm_ok) begin
                        w_state_nxt = S_ALARM;
                        w_enter     = 1'b1;
                        w_step_nxt  = 3'd0;
                        w_nco_nxt   = melody(3'd0);
                        w_buzz_nxt  = 1'b1;
                        w_grant_nxt = 3'b100;
                    end else if (r_pend_chime | i_chime_req) begin
                        w_state_nxt      = S_CHIME_ON;
                        w_enter          = 1'b1;
                        w_pend_chime_nxt = 1'b0;
                        w_beep_nxt       = 8'd0;
                        w_nco_nxt        = 32'(TONE_CHIME);
                        w_buzz_nxt       = 1'b1;
                        w_grant_nxt      = 3'b010;
                    end else if (r_pend_key | i_key_req) begin
                        w_state_nxt    = S_KEY;
                        w_enter        = 1'b1;
                        w_pend_key_nxt = 1'b0;
                        w_nco_nxt      = 32'(TONE_KEY);
                        w_buzz_nxt     = 1'b1;
                        w_grant_nxt    = 3'b001;
                    end
                end
                S_KEY, S_CHIME_ON, S_CHIME_OFF: begin
                    if (w_alarm_ok) begin
                        // Preempted sound is abandoned, not resumed
                        w_state_nxt = S_ALARM;
                        w_enter     = 1'b1;
                        w_step_nxt  = 3'd0;
                        w_nco_nxt   = melody(3'd0);
                        w_buzz_nxt  = 1'b1;
                        w_grant_nxt = 3'b100;
                    end else if (r_state == S_KEY) begin
                        if (w_tick && r_ticks == 16'(KEY_TICKS - 1)) begin
                            w_state_nxt = S_IDLE;
                            w_enter     = 1'b1;
                            w_buzz_nxt  = 1'b0;
                            w_grant_nxt = 3'b000;
                        end
                    end else if (r_state == S_CHIME_ON) begin
                        if (w_tick && r_ticks == 16'(CHIME_ON - 1)) begin
                            w_enter    = 1'b1;
                            w_buzz_nxt = 1'b0;
                            if (r_beep == 8'(CHIME_BEEPS - 1)) begin
                                w_state_nxt = S_IDLE;
                                w_grant_nxt = 3'b000;
                            end else begin
                                w_state_nxt = S_CHIME_OFF;
                            end
                        end
                    end else begin
                        if (w_tick && r_ticks == 16'(CHIME_OFF - 1)) begin
                            w_state_nxt = S_CHIME_ON;
                            w_enter     = 1'b1;
                            w_beep_nxt  = r_beep + 8'd1;
                            w_buzz_nxt  = 1'b1;
                        end
                    end
                end
                S_ALARM: begin
                    if (!w_alarm_ok) begin
                        w_state_nxt = S_IDLE;
                        w_enter     = 1'b1;
                        w_buzz_nxt  = 1'b0;
                        w_grant_nxt = 3'b000;
                    end else if (w_tick && r_ticks == 16'(ALARM_STEP - 1)) begin
                        w_ticks_nxt = 16'd0;
                        w_step_nxt  = r_step + 3'd1;
                        w_nco_nxt   = melody(r_step + 3'd1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_enter     = 1'b1;
                    w_buzz_nxt  = 1'b0;
                    w_grant_nxt = 3'b000;
                end
            endcase
        end

        // Every state entry restarts the duration timebase
        if (w_enter) begin
            w_prescale_nxt = '0;
            w_ticks_nxt    = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prescale   <= '0;
            r_ticks      <= 16'd0;
            r_beep       <= 8'd0;
            r_step       <= 3'd0;
            r_pend_chime <= 1'b0;
            r_pend_key   <= 1'b0;
            r_mask       <= 1'b0;
            r_nco        <= 32'd0;
            r_buzz       <= 1'b0;
            r_grant      <= 3'b000;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prescale   <= w_prescale_nxt;
            r_ticks      <= w_ticks_nxt;
            r_beep       <= w_beep_nxt;
            r_step       <= w_step_nxt;
            r_pend_chime <= w_pend_chime_nxt;
            r_pend_key   <= w_pend_key_nxt;
            r_mask       <= w_mask_nxt;
            r_nco        <= w_nco_nxt;
            r_buzz       <= w_buzz_nxt;
            r_grant      <= w_grant_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_nco_num = r_nco;
    assign o_buzz_en = r_buzz;
    assign o_grant   = r_grant;
    assign o_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_buzz_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_buzz_sched
// Purpose  : Self-checking bench for buzz_sched against a timeline model.
// Revision : 1.0  initial release
// ============================================================================
module tb_buzz_sched;

    localparam int TD   = 4;
    localparam int KT   = 2;
    localparam int CON  = 3;
    localparam int COFF = 2;
    localparam int CB   = 3;
    localparam int AS   = 2;
    localparam int TONE_KEY   = 6327;
    localparam int TONE_CHIME = 7102;

    localparam int M_NONE  = 0;
    localparam int M_KEY   = 1;
    localparam int M_CHIME = 2;
    localparam int M_ALARM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alarm_req = 1'b0;
    logic        chime_req = 1'b0;
    logic        key_req = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] nco_num;
    logic        buzz_en;
    logic [2:0]  grant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    buzz_sched #(
        .TICK_DIV(TD), .KEY_TICKS(KT), .CHIME_ON(CON), .CHIME_OFF(COFF),
        .CHIME_BEEPS(CB), .ALARM_STEP(AS), .TONE_KEY(TONE_KEY), .TONE_CHIME(TONE_CHIME)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_alarm_req(alarm_req), .i_chime_req(chime_req),
        .i_key_req(key_req), .i_stop(stop), .o_nco_num(nco_num), .o_buzz_en(buzz_en),
        .o_grant(grant), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Model: who owns the buzzer and how many cycles since that sound started
    int          m_owner = M_NONE;
    int          m_t = 0;
    bit          m_pc = 0, m_pk = 0, m_mask = 0;
    logic [31:0] m_nco = 32'd0;
    int          melody [8] = '{9480, 10641, 11944, 10641, 9480, 9480, 9480, 10641};

    function automatic int dur(int o);
        if (o == M_KEY)   return KT * TD;
        if (o == M_CHIME) return (CB * CON + (CB - 1) * COFF) * TD;
        return -1;
    endfunction

    function automatic void model_edge(bit rst, bit a, bit c, bit k, bit s);
        bit ok;
        if (!rst) begin
            m_owner = M_NONE; m_t = 0; m_pc = 0; m_pk = 0; m_mask = 0; m_nco = 32'd0;
            return;
        end
        ok     = a && !m_mask;
        m_mask = a && (m_mask || s);
        if (s) begin
            m_owner = M_NONE; m_pc = 0; m_pk = 0;
        end else if (m_owner == M_NONE) begin
            if (ok) begin
                m_owner = M_ALARM; m_t = 0; m_pc = m_pc | c; m_pk = m_pk | k;
            end else if (m_pc || c) begin
                m_owner = M_CHIME; m_t = 0; m_pc = 0; m_pk = m_pk | k;
            end else if (m_pk || k) begin
                m_owner = M_KEY; m_t = 0; m_pk = 0;
            end
        end else begin
            m_pc = m_pc | c;
            m_pk = m_pk | k;
            if (m_owner == M_ALARM) begin
                if (!ok) m_owner = M_NONE;
                else     m_t++;
            end else if (ok) begin
                m_owner = M_ALARM; m_t = 0;
            end else begin
                m_t++;
                if (m_t == dur(m_owner)) m_owner = M_NONE;
            end
        end
        case (m_owner)
            M_KEY:   m_nco = TONE_KEY;
            M_CHIME: m_nco = TONE_CHIME;
            M_ALARM: m_nco = melody[(m_t / (AS * TD)) % 8];
            default: ;
        endcase
    endfunction

    // Packed {grant, buzz_en, busy, nco}
    function automatic logic [36:0] m_exp();
        logic [2:0] g;
        logic       b;
        g = 3'b000;
        b = 1'b0;
        case (m_owner)
            M_KEY:   begin g = 3'b001; b = 1'b1; end
            M_CHIME: begin g = 3'b010; b = ((m_t % ((CON + COFF) * TD)) < CON * TD); end
            M_ALARM: begin g = 3'b100; b = 1'b1; end
            default: ;
        endcase
        return {g, b, (m_owner != M_NONE), m_nco};
    endfunction

    task automatic cyc(bit a, bit c, bit k, bit s);
        alarm_req = a; chime_req = c; key_req = k; stop = s;
        @(posedge clk);
        model_edge(rst_n, a, c, k, s);
        #1;
        chime_req = 1'b0; key_req = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
            if ({grant, buzz_en, busy, nco_num} !== 37'd0) begin
                errors++;
                $display("FAIL reset cyc %0d: got %h want 0", i, {grant, buzz_en, busy, nco_num});
            end
            checks++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_key();
        int on_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, (i == 0), 1'b0);
            if ({grant, buzz_en, busy, nco_num} !== m_exp()) begin
                errors++;
                $display("FAIL key cyc %0d: got %h want %h", i, {grant, buzz_en, busy, nco_num}, m_exp());
            end
            checks++;
            if (buzz_en === 1'b1 && grant === 3'b001) on_cnt++;
        end
        if (on_cnt != KT * TD || nco_num !== 32'd6327) begin
            errors++;
            $display("FAIL key_len: got %0d cycles nco %0d want %0d cycles nco 6327", on_cnt, nco_num, KT * TD);
        end
        checks++;
    endtask

    task automatic test_chime();
        int busy_cnt = 0, on_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0, (i == 0), 1'b0, 1'b0);
            if ({grant, buzz_en, busy, nco_num} !== m_exp()) begin
                errors++;
                $display("FAIL chime cyc %0d: got %h want %h", i, {grant, buzz_en, busy, nco_num}, m_exp());
            end
            checks++;
            if (busy === 1'b1) busy_cnt++;
            if (buzz_en === 1'b1) on_cnt++;
        end
        if (busy_cnt != 52 || on_cnt != 36) begin
            errors++;
            $display("FAIL chime_len: got busy %0d on %0d want busy 52 on 36", busy_cnt, on_cnt);
        end
        checks++;
    endtask

    task automatic test_chime_key();
        int key_cnt = 0, busy_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            cyc(1'b0, (i == 0), (i == 0), 1'b0);
            if ({grant, buzz_en, busy, nco_num} !== m_exp()) begin
                errors++;
                $display("FAIL chime_key cyc %0d: got %h want %h", i, {grant, buzz_en, busy, nco_num}, m_exp());
            end
            checks++;
            if (grant === 3'b001) key_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
        if (key_cnt != KT * TD || busy_cnt != 52 + KT * TD) begin
            errors++;
            $display("FAIL chime_key_len: got key %0d busy %0d want key 8 busy 60", key_cnt, busy_cnt);
        end
        checks++;
    endtask

    task automatic test_alarm_preempt();
        int chime_after = 0;
        for (int i = 0; i < 25; i++) cyc(1'b0, (i == 0), 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        if (grant !== 3'b100 || nco_num !== 32'd9480 || buzz_en !== 1'b1) begin
            errors++;
            $display("FAIL preempt: got grant %b nco %0d want grant 100 nco 9480", grant, nco_num);
        end
        checks++;
        for (int i = 0; i < 80; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if ({grant, buzz_en, busy, nco_num} !== m_exp()) begin
                errors++;
                $display("FAIL alarm cyc %0d: got %h want %h", i, {grant, buzz_en, busy, nco_num}, m_exp());
            end
            checks++;
        end
        for (int i = 0; i < 70; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (grant === 3'b010) chime_after++;
        end
        if (chime_after != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_resume: got %0d chime cycles busy %b want 0", chime_after, busy);
        end
        checks++;
    endtask

    task automatic test_stop();
        int loud = 0;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        if (busy !== 1'b0 || buzz_en !== 1'b0 || grant !== 3'b000) begin
            errors++;
            $display("FAIL stop: got busy %b buzz %b grant %b want 0 0 000", busy, buzz_en, grant);
        end
        checks++;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (busy !== 1'b0) loud++;
            if ({grant, buzz_en, busy, nco_num} !== m_exp()) begin
                errors++;
                $display("FAIL stop_hold cyc %0d: got %h want %h", i, {grant, buzz_en, busy, nco_num}, m_exp());
            end
            checks++;
        end
        if (loud != 0) begin
            errors++;
            $display("FAIL stop_mask: got %0d busy cycles want 0", loud);
        end
        checks++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        if (grant !== 3'b100 || nco_num !== 32'd9480) begin
            errors++;
            $display("FAIL rearm: got grant %b nco %0d want 100 9480", grant, nco_num);
        end
        checks++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_alarm();
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        if ({grant, buzz_en, busy, nco_num} !== 37'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h want 0", {grant, buzz_en, busy, nco_num});
        end
        checks++;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        if (grant !== 3'b100 || nco_num !== 32'd9480) begin
            errors++;
            $display("FAIL reset_restart: got grant %b nco %0d want 100 9480", grant, nco_num);
        end
        checks++;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if ({grant, buzz_en, busy, nco_num} !== m_exp()) begin
                errors++;
                $display("FAIL reset_step cyc %0d: got %h want %h", i, {grant, buzz_en, busy, nco_num}, m_exp());
            end
            checks++;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit a = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(149) == 0) a = ~a;
            rst_n = ($urandom_range(599) != 0);
            cyc(a, ($urandom_range(59) == 0), ($urandom_range(24) == 0), ($urandom_range(119) == 0));
            if ({grant, buzz_en, busy, nco_num} !== m_exp()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, {grant, buzz_en, busy, nco_num}, m_exp());
            end
            checks++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_key();
        test_chime();
        test_chime_key();
        test_alarm_preempt();
        test_stop();
        test_reset_mid_alarm();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
